// File: rtl/video_timing_pkg.sv
// Shared constants and helpers for the video timing generator.
//   - Default raster timing (pixels, lines, blanking and sync windows)
//   - Sync adjustment widths and range limits
//   - Modulo window helpers used by the sync decoders
package video_timing_pkg;

  localparam int unsigned CNT_W   = 9;
  localparam int unsigned H_ADJ_W = 4;
  localparam int unsigned V_ADJ_W = 3;

  localparam int H_ADJ_MIN = -8;
  localparam int H_ADJ_MAX = 7;
  localparam int V_ADJ_MIN = -4;
  localparam int V_ADJ_MAX = 3;

  localparam int unsigned DEF_CLK_DIV  = 7;
  localparam int unsigned DEF_H_TOTAL  = 384;
  localparam int unsigned DEF_H_BEND   = 17;
  localparam int unsigned DEF_H_BSTART = 256;
  localparam int unsigned DEF_HS_START = 309;
  localparam int unsigned DEF_HS_END   = 341;
  localparam int unsigned DEF_V_TOTAL  = 263;
  localparam int unsigned DEF_V_BEND   = 9;
  localparam int unsigned DEF_V_BSTART = 248;
  localparam int unsigned DEF_VS_START = 250;
  localparam int unsigned DEF_VS_END   = 253;

  // Blanking (active high) and sync (active low) flags, registered together.
  typedef struct packed {
    logic hb;
    logic vb;
    logic hs;
    logic vs;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hb: 1'b1, vb: 1'b1, hs: 1'b1, vs: 1'b1};

  // base+adj folded into [0, total); adj magnitude is always below total.
  function automatic logic [CNT_W-1:0] wrap_pos(input int base, input int adj, input int total);
    int v;
    v = base + adj;
    if (v < 0) v = v + total;
    else if (v >= total) v = v - total;
    return CNT_W'(v);
  endfunction

  // Half-open window [lo, hi) that may straddle the wrap point.
  function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    if (lo <= hi) return (pos >= lo) && (pos < hi);
    return (pos >= lo) || (pos < hi);
  endfunction

endpackage

// File: rtl/pix_clk_en.sv
// Pixel clock-enable divider.
//   clk_sys  : system clock
//   reset_n  : asynchronous active-low reset
//   ce_pix   : registered one-cycle enable, every CLK_DIV cycles
//   tick_c   : combinational early copy of ce_pix (high the cycle before)
module pix_clk_en #(
  parameter int unsigned CLK_DIV = 7
) (
  input  logic clk_sys,
  input  logic reset_n,
  output logic ce_pix,
  output logic tick_c
);

  localparam int unsigned       DIV_W    = 4;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (CLK_DIV < 2 || CLK_DIV > 15) begin : g_bad_div
    $fatal(1, "pix_clk_en: CLK_DIV must be 2..15");
  end

  logic [DIV_W-1:0] div_q;

  assign tick_c = (div_q == DIV_LAST);

  // Free-running divider; first enable lands CLK_DIV cycles after reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      ce_pix <= 1'b0;
    end else begin
      ce_pix <= tick_c;
      div_q  <= tick_c ? '0 : div_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, blanking, sync and
// frame pulses, with per-frame horizontal/vertical sync adjustment.
//   clk_sys, reset_n        : clock, asynchronous active-low reset
//   h_adj, v_adj            : signed sync shifts, latched at frame wrap
//   ce_pix                  : pixel enable
//   hcount, vcount          : pixel and line position
//   hb, vb / hs, vs         : blanking (active high) / sync (active low)
//   field                   : interlaced field (0 even, 1 odd)
//   line_start, frame_start : pulses on the ce_pix cycle a line/frame begins
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned H_TOTAL   = DEF_H_TOTAL,
  parameter int unsigned H_BEND    = DEF_H_BEND,
  parameter int unsigned H_BSTART  = DEF_H_BSTART,
  parameter int unsigned HS_START  = DEF_HS_START,
  parameter int unsigned HS_END    = DEF_HS_END,
  parameter int unsigned V_TOTAL   = DEF_V_TOTAL,
  parameter int unsigned V_BEND    = DEF_V_BEND,
  parameter int unsigned V_BSTART  = DEF_V_BSTART,
  parameter int unsigned VS_START  = DEF_VS_START,
  parameter int unsigned VS_END    = DEF_VS_END,
  parameter int unsigned INTERLACE = 0
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic signed [H_ADJ_W-1:0] h_adj,
  input  logic signed [V_ADJ_W-1:0] v_adj,
  output logic                      ce_pix,
  output logic [CNT_W-1:0]          hcount,
  output logic [CNT_W-1:0]          vcount,
  output logic                      hb,
  output logic                      vb,
  output logic                      hs,
  output logic                      vs,
  output logic                      field,
  output logic                      line_start,
  output logic                      frame_start
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);

  if (!(H_BEND < H_BSTART && H_BSTART <= H_TOTAL) ||
      (int'(HS_END) - int'(HS_START) >= int'(H_TOTAL)) ||
      H_TOTAL > 512 || V_TOTAL > 511 ||
      !(V_BEND < V_BSTART && V_BSTART <= V_TOTAL) ||
      (int'(VS_END) - int'(VS_START) >= int'(V_TOTAL))) begin : g_bad_params
    $fatal(1, "video_timing_gen: inconsistent timing parameters");
  end

  logic                      tick_c;
  logic                      h_wrap_c;
  logic                      v_wrap_c;
  logic                      field_nxt_c;
  logic [CNT_W-1:0]          h_nxt_c;
  logic [CNT_W-1:0]          v_nxt_c;
  logic [CNT_W-1:0]          v_last_c;
  logic signed [H_ADJ_W-1:0] h_adj_q;
  logic signed [H_ADJ_W-1:0] h_adj_nxt_c;
  logic signed [V_ADJ_W-1:0] v_adj_q;
  logic signed [V_ADJ_W-1:0] v_adj_nxt_c;
  logic [CNT_W-1:0]          hs_lo_c;
  logic [CNT_W-1:0]          hs_hi_c;
  logic [CNT_W-1:0]          vs_lo_c;
  logic [CNT_W-1:0]          vs_hi_c;
  sync_t                     sync_q;
  sync_t                     sync_nxt_c;

  pix_clk_en #(.CLK_DIV(CLK_DIV)) u_pix_clk_en (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ce_pix  (ce_pix),
    .tick_c  (tick_c)
  );

  // Counter advance; counts update on the same edge ce_pix rises.
  always_comb begin
    h_wrap_c    = (hcount == H_LAST);
    h_nxt_c     = h_wrap_c ? '0 : hcount + CNT_W'(1);
    v_last_c    = (INTERLACE != 0 && field) ? CNT_W'(V_TOTAL) : CNT_W'(V_TOTAL - 1);
    v_wrap_c    = h_wrap_c && (vcount == v_last_c);
    v_nxt_c     = vcount;
    if (h_wrap_c) v_nxt_c = v_wrap_c ? '0 : vcount + CNT_W'(1);
    field_nxt_c = field ^ (v_wrap_c && INTERLACE != 0);
    // The new frame already decodes with the freshly latched adjustment.
    h_adj_nxt_c = v_wrap_c ? h_adj : h_adj_q;
    v_adj_nxt_c = v_wrap_c ? v_adj : v_adj_q;
  end

  // Blanking/sync decode from the next counts so all outputs stay aligned.
  always_comb begin
    hs_lo_c       = wrap_pos(int'(HS_START), int'(h_adj_nxt_c), int'(H_TOTAL));
    hs_hi_c       = wrap_pos(int'(HS_END),   int'(h_adj_nxt_c), int'(H_TOTAL));
    vs_lo_c       = wrap_pos(int'(VS_START), int'(v_adj_nxt_c), int'(V_TOTAL));
    vs_hi_c       = wrap_pos(int'(VS_END),   int'(v_adj_nxt_c), int'(V_TOTAL));
    sync_nxt_c    = SYNC_IDLE;
    sync_nxt_c.hb = !(int'(h_nxt_c) >= int'(H_BEND) && int'(h_nxt_c) < int'(H_BSTART));
    sync_nxt_c.vb = !(int'(v_nxt_c) >= int'(V_BEND) && int'(v_nxt_c) < int'(V_BSTART));
    sync_nxt_c.hs = !in_window(h_nxt_c, hs_lo_c, hs_hi_c);
    sync_nxt_c.vs = !in_window(v_nxt_c, vs_lo_c, vs_hi_c);
  end

  // Timing state; pulses clear on every non-pixel cycle.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hcount      <= '0;
      vcount      <= '0;
      field       <= 1'b0;
      h_adj_q     <= '0;
      v_adj_q     <= '0;
      sync_q      <= SYNC_IDLE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (tick_c) begin
        hcount      <= h_nxt_c;
        vcount      <= v_nxt_c;
        field       <= field_nxt_c;
        h_adj_q     <= h_adj_nxt_c;
        v_adj_q     <= v_adj_nxt_c;
        sync_q      <= sync_nxt_c;
        line_start  <= h_wrap_c;
        frame_start <= v_wrap_c;
      end
    end
  end

  assign hb = sync_q.hb;
  assign vb = sync_q.vb;
  assign hs = sync_q.hs;
  assign vs = sync_q.vs;

endmodule
